// File: rtl/serial_pkg.sv
// Shared definitions for the lab serial link: transmitter FSM states and line levels.
// The matching receiver imports this same package.
`timescale 1ns/1ps
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit period timer: o_tick marks the last cycle of every CLKS_PER_BIT-cycle period.
// Holding i_clear keeps the count at zero, so a period begins on the cycle after release.
`timescale 1ns/1ps
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // With CLKS_PER_BIT=1 LAST_CNT is zero, so every cycle ticks.
    assign o_tick = (cnt == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, DATA_WIDTH data bits LSB first,
// stop bit, each bit held CLKS_PER_BIT cycles on a registered, idle-high line.
`timescale 1ns/1ps
module piso_serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [IW-1:0]         bit_idx, bit_idx_next;
    logic                  tx_q, tx_next;
    logic                  tick;

    // Timer is held cleared while idle so the start bit always gets a full period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(state == S_IDLE),
        .o_tick (tick)
    );

    // Handshake: a word transfers on a rising edge where i_valid && o_ready; o_ready is
    // high only in IDLE, and i_valid/i_data are ignored in every other state.
    assign o_ready = (state == S_IDLE);
    assign o_busy  = (state != S_IDLE);
    assign o_done  = (state == S_STOP) && tick;
    assign o_tx    = tx_q;

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        tx_next      = LINE_IDLE;

        case (state)
            S_IDLE: begin
                if (i_valid) begin
                    state_next   = S_START;
                    shreg_next   = i_data;
                    bit_idx_next = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_next   = S_DATA;
                    bit_idx_next = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next = S_STOP;
                    end else begin
                        shreg_next   = shreg >> 1;
                        bit_idx_next = bit_idx + IW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // The line register is loaded with the level of the state being entered,
        // so o_tx changes on the same edge as the state.
        case (state_next)
            S_START: tx_next = START_BIT;
            S_DATA:  tx_next = shreg_next[0];
            S_STOP:  tx_next = STOP_BIT;
            default: tx_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            tx_q    <= LINE_IDLE;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_idx <= bit_idx_next;
            tx_q    <= tx_next;
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: one 8-bit/4-clock instance and one 8-bit/1-clock instance.
`timescale 1ns/1ps
module tb_piso_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready, tx, busy, done;

    logic       valid1;
    logic [7:0] data1;
    logic       ready1, tx1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;

    // Frames as {stop, data, start}; bit k is the k-th bit period on the line.
    logic [9:0] frm_a5 = 10'b1101001010;
    logic [9:0] frm_3c = 10'b1001111000;
    logic [9:0] frm_01 = 10'b1000000010;
    logic [9:0] frm_80 = 10'b1100000000;
    logic [9:0] frm_ff = 10'b1111111110;
    logic [9:0] frm_55 = 10'b1010101010;

    always #5 clk = ~clk;

    piso_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(valid),
        .i_data (data),
        .o_ready(ready),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    piso_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(valid1),
        .i_data (data1),
        .o_ready(ready1),
        .o_tx   (tx1),
        .o_busy (busy1),
        .o_done (done1)
    );

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hA5;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({tx, ready, busy, done} !== 4'b1100) begin
                miscompares++;
                $display("FAIL reset_state c=%0d tx/ready/busy/done=%b expected 1100", c, {tx, ready, busy, done});
            end
        end
        valid = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({tx, ready, busy, done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_no_frame tx/ready/busy/done=%b expected 1100", {tx, ready, busy, done});
        end
    endtask

    task automatic test_single_frame();
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready_before got %b expected 1", ready);
        end
        valid = 1'b1;
        data  = 8'hA5;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            vectors++;
            if (tx !== frm_a5[(c-1)/4] || busy !== 1'b1 || ready !== 1'b0 || done !== (c == 40)) begin
                miscompares++;
                $display("FAIL single_frame cycle=%0d tx=%b busy=%b ready=%b done=%b expected tx=%b busy=1 ready=0 done=%b",
                         c, tx, busy, ready, done, frm_a5[(c-1)/4], (c == 40));
            end
        end
        @(negedge clk);
        vectors++;
        if ({tx, ready, busy, done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL single_after cycle=41 tx/ready/busy/done=%b expected 1100", {tx, ready, busy, done});
        end
    endtask

    task automatic test_input_stability();
        valid = 1'b1;
        data  = 8'h3C;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (c == 1) data = 8'hFF;
            vectors++;
            if (c <= 40) begin
                if (tx !== frm_3c[(c-1)/4] || ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stability cycle=%0d tx=%b ready=%b expected tx=%b ready=0", c, tx, ready, frm_3c[(c-1)/4]);
                end
            end else if (ready !== 1'b1 || tx !== 1'b1) begin
                miscompares++;
                $display("FAIL stability_idle cycle=41 ready=%b tx=%b expected ready=1 tx=1", ready, tx);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        vectors++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stability_next_start tx=%b busy=%b expected tx=0 busy=1", tx, busy);
        end
        // The 0xFF frame occupies the line from here; walk its data bits then wait for idle.
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            vectors++;
            if (tx !== frm_ff[(c-1)/4]) begin
                miscompares++;
                $display("FAIL stability_ff cycle=%0d tx=%b expected %b", c, tx, frm_ff[(c-1)/4]);
            end
        end
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stability_ff_end ready=%b expected 1", ready);
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        logic [9:0] frm;
        valid = 1'b1;
        data  = 8'h01;
        for (int c = 1; c <= 82; c++) begin
            @(negedge clk);
            if (c == 1) data = 8'h80;
            if (c == 42) valid = 1'b0;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            vectors++;
            if (c <= 40) begin
                frm = frm_01;
                if (tx !== frm[(c-1)/4]) begin
                    miscompares++;
                    $display("FAIL b2b_frame1 cycle=%0d tx=%b expected %b", c, tx, frm[(c-1)/4]);
                end
            end else if (c == 41 || c == 82) begin
                if (tx !== 1'b1 || ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_idle cycle=%0d tx=%b ready=%b expected tx=1 ready=1", c, tx, ready);
                end
            end else begin
                frm = frm_80;
                if (tx !== frm[(c-42)/4]) begin
                    miscompares++;
                    $display("FAIL b2b_frame2 cycle=%0d tx=%b expected %b", c, tx, frm[(c-42)/4]);
                end
            end
        end
        vectors++;
        if (d1 != 40 || d2 != 81) begin
            miscompares++;
            $display("FAIL b2b_done done_cycles=%0d,%0d expected 40,81", d1, d2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int extra_done = 0;
        valid = 1'b1;
        data  = 8'h00;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
        end
        // Cycle 18 lies inside data bit 3 (cycles 17..20).
        vectors++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_before tx=%b busy=%b expected tx=0 busy=1", tx, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({tx, ready, busy, done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL midrst_after tx/ready/busy/done=%b expected 1100", {tx, ready, busy, done});
        end
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1) extra_done++;
        end
        vectors++;
        if (extra_done != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet bad_cycles=%0d expected 0", extra_done);
        end
        valid = 1'b1;
        data  = 8'hFF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            vectors++;
            if (tx !== frm_ff[(c-1)/4] || done !== (c == 40)) begin
                miscompares++;
                $display("FAIL midrst_ff cycle=%0d tx=%b done=%b expected tx=%b done=%b",
                         c, tx, done, frm_ff[(c-1)/4], (c == 40));
            end
        end
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_ff_end ready=%b expected 1", ready);
        end
    endtask

    task automatic test_cpb1();
        int waited = 0;
        while (ready1 !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (ready1 !== 1'b1) begin
            miscompares++;
            $display("FAIL cpb1_ready_timeout ready=%b expected 1", ready1);
        end
        valid1 = 1'b1;
        data1  = 8'h55;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) valid1 = 1'b0;
            vectors++;
            if (tx1 !== frm_55[c-1] || busy1 !== 1'b1 || done1 !== (c == 10)) begin
                miscompares++;
                $display("FAIL cpb1_frame cycle=%0d tx=%b busy=%b done=%b expected tx=%b busy=1 done=%b",
                         c, tx1, busy1, done1, frm_55[c-1], (c == 10));
            end
        end
        @(negedge clk);
        vectors++;
        if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
            miscompares++;
            $display("FAIL cpb1_after tx/ready/busy/done=%b expected 1100", {tx1, ready1, busy1, done1});
        end
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        data   = 8'h00;
        valid1 = 1'b0;
        data1  = 8'h00;
        test_reset();
        test_single_frame();
        test_input_stability();
        test_back_to_back();
        test_reset_mid_frame();
        test_cpb1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
